// File: rtl/sort4_serial_if.sv
// Stream bundle for sort4_serial: an input valid/ready channel and a sorted output channel.
// The slave modport is the sorter; the master modport is whoever feeds and drains it.
interface sort4_serial_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/sort4_serial.sv
// Serial 4-value sorter: loads four values, sorts them with a four-phase odd-even
// transposition network, then streams them out one per accepted transfer.
module sort4_serial #(
  parameter int W       = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  sort4_serial_if.slave bus,
  output logic [2:0]   swaps,
  output logic         busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   idx;
  logic [1:0]   oidx;
  logic [1:0]   phase;
  logic [W-1:0] r [4];

  logic         in_fire;
  logic         out_fire;
  logic         swap01;
  logic         swap12;
  logic         swap23;
  logic [2:0]   phase_swaps;

  // Strict comparison keeps equal values in place, which makes the sort stable.
  function automatic logic out_of_order(input logic [W-1:0] lhs, input logic [W-1:0] rhs);
    return DESCEND ? (lhs < rhs) : (lhs > rhs);
  endfunction

  assign in_fire  = bus.in_valid && (state == LOAD);
  assign out_fire = bus.out_ready && (state == OUT);

  assign swap01 = out_of_order(r[0], r[1]);
  assign swap12 = out_of_order(r[1], r[2]);
  assign swap23 = out_of_order(r[2], r[3]);

  always_comb begin
    phase_swaps = 3'd0;
    if (!phase[0]) begin
      phase_swaps = {2'b00, swap01} + {2'b00, swap23};
    end else begin
      phase_swaps = {2'b00, swap12};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: begin
        if (in_fire && (idx == 2'd3)) begin
          state_nxt = SORT;
        end
      end
      SORT: begin
        if (phase == 2'd3) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_fire && (oidx == 2'd3)) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs depend only on registered state, so out_data has no path from any input.
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.out_valid = (state == OUT);
    bus.out_last  = (state == OUT) && (oidx == 2'd3);
    bus.out_data  = (state == OUT) ? r[oidx] : '0;
    busy          = (state == SORT) || (state == OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= 2'd0;
      oidx  <= 2'd0;
      phase <= 2'd0;
      swaps <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r[i] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          oidx <= 2'd0;
          if (in_fire) begin
            r[idx] <= bus.in_data;
            idx    <= idx + 2'd1;
            if (idx == 2'd3) begin
              phase <= 2'd0;
              swaps <= 3'd0;
            end
          end
        end
        SORT: begin
          if (!phase[0]) begin
            if (swap01) begin
              r[0] <= r[1];
              r[1] <= r[0];
            end
            if (swap23) begin
              r[2] <= r[3];
              r[3] <= r[2];
            end
          end else if (swap12) begin
            r[1] <= r[2];
            r[2] <= r[1];
          end
          swaps <= swaps + phase_swaps;
          phase <= phase + 2'd1;
        end
        OUT: begin
          if (out_fire) begin
            oidx <= oidx + 2'd1;
          end
        end
        default: begin
          idx <= 2'd0;
        end
      endcase
    end
  end

endmodule
